// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder emulating a 3-axis accelerometer register file.
// SPI pins are oversampled in the clk domain; all state lives in clk.
`timescale 1ns/1ps
module spi_accel_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        int1,
    output logic [7:0]  reg_bw_rate,
    output logic [7:0]  reg_power_ctl,
    output logic [7:0]  reg_data_format,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [1:0] {IDLE, CMD, RD_DATA, WR_DATA} state_t;

    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, sdi_sync_q;
    logic csn_prev_q, sclk_prev_q;
    logic csn_s, sclk_s, sdi_s, csn_fall, csn_rise, sclk_fall, sclk_rise;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [5:0]  addr_q, addr_d;
    logic        mb_q, mb_d, load_q, load_d, sdo_q, sdo_d, oe_q, oe_d;
    logic [7:0]  bw_q, bw_d, pwr_q, pwr_d, ien_q, ien_d, fmt_q, fmt_d;
    logic [47:0] live_q, live_d, shadow_q, shadow_d;
    logic        dready_q, dready_d, int1_q, int1_d, rd_clr;
    logic        wr_strobe_q, wr_strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rx_byte, rd_byte;
    logic [5:0]  next_addr;
    logic        addr_rw;

    // csn resets as if already low, so a transaction in flight at reset release never produces a fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csn_sync_q  <= '0;
            sclk_sync_q <= '1;
            sdi_sync_q  <= '0;
            csn_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b1;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            csn_prev_q  <= csn_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign csn_fall  = csn_prev_q & ~csn_s;
    assign csn_rise  = ~csn_prev_q & csn_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;

    assign rx_byte   = {shift_q, sdi_s};
    assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;
    assign addr_rw   = (addr_q == 6'h2C) || (addr_q == 6'h2D) ||
                       (addr_q == 6'h2E) || (addr_q == 6'h31);

    always_comb begin
        rd_byte = 8'h00;
        case (addr_q)
            6'h00:   rd_byte = DEVID;
            6'h2C:   rd_byte = bw_q;
            6'h2D:   rd_byte = pwr_q;
            6'h2E:   rd_byte = ien_q;
            6'h30:   rd_byte = {dready_q, 7'b0};
            6'h31:   rd_byte = fmt_q;
            6'h32:   rd_byte = shadow_q[7:0];
            6'h33:   rd_byte = shadow_q[15:8];
            6'h34:   rd_byte = shadow_q[23:16];
            6'h35:   rd_byte = shadow_q[31:24];
            6'h36:   rd_byte = shadow_q[39:32];
            6'h37:   rd_byte = shadow_q[47:40];
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        mb_d        = mb_q;
        load_d      = load_q;
        sdo_d       = sdo_q;
        oe_d        = oe_q;
        bw_d        = bw_q;
        pwr_d       = pwr_q;
        ien_d       = ien_q;
        fmt_d       = fmt_q;
        shadow_d    = shadow_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_clr      = 1'b0;
        if (csn_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            load_d    = 1'b0;
            sdo_d     = 1'b0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (csn_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                    shadow_d  = live_q;
                end
                CMD: if (sclk_rise) begin
                    shift_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d  = rx_byte[5:0];
                        mb_d    = rx_byte[6];
                        load_d  = 1'b1;
                        state_d = rx_byte[7] ? RD_DATA : WR_DATA;
                    end
                end
                RD_DATA: begin
                    // first fall of each byte fetches the register; later falls shift it out
                    if (sclk_fall) begin
                        oe_d = 1'b1;
                        if (load_q) begin
                            sdo_d  = rd_byte[7];
                            tx_d   = {rd_byte[6:0], 1'b0};
                            load_d = 1'b0;
                        end else begin
                            sdo_d = tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            load_d = 1'b1;
                            addr_d = next_addr;
                            rd_clr = (addr_q == 6'h37);
                        end
                    end
                end
                WR_DATA: if (sclk_rise) begin
                    shift_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = next_addr;
                        if (addr_rw) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = rx_byte;
                        end
                        case (addr_q)
                            6'h2C:   bw_d  = rx_byte;
                            6'h2D:   pwr_d = rx_byte;
                            6'h2E:   ien_d = rx_byte;
                            6'h31:   fmt_d = rx_byte;
                            default: ;
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // a new sample takes priority over the clear from reading DATAZ1
    assign live_d   = sample_valid ? {sample_z, sample_y, sample_x} : live_q;
    assign dready_d = sample_valid | (dready_q & ~rd_clr);
    assign int1_d   = dready_q & ien_q[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            tx_q        <= 8'd0;
            addr_q      <= 6'd0;
            mb_q        <= 1'b0;
            load_q      <= 1'b0;
            sdo_q       <= 1'b0;
            oe_q        <= 1'b0;
            bw_q        <= BW_RATE_RST;
            pwr_q       <= 8'd0;
            ien_q       <= 8'd0;
            fmt_q       <= 8'd0;
            live_q      <= 48'd0;
            shadow_q    <= 48'd0;
            dready_q    <= 1'b0;
            int1_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            mb_q        <= mb_d;
            load_q      <= load_d;
            sdo_q       <= sdo_d;
            oe_q        <= oe_d;
            bw_q        <= bw_d;
            pwr_q       <= pwr_d;
            ien_q       <= ien_d;
            fmt_q       <= fmt_d;
            live_q      <= live_d;
            shadow_q    <= shadow_d;
            dready_q    <= dready_d;
            int1_q      <= int1_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign spi_sdo         = sdo_q & oe_q;
    assign spi_sdo_oe      = oe_q;
    assign int1            = int1_q;
    assign reg_bw_rate     = bw_q;
    assign reg_power_ctl   = pwr_q;
    assign reg_data_format = fmt_q;
    assign wr_strobe       = wr_strobe_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
SPI responder (slave) that models the board's 3-axis accelerometer register interface: SPI mode 3, 4-wire, 8-bit command byte followed by data bytes. It serves live or test samples and configuration registers to an spi_control-style initiator. Used as a bench model for the accelerometer path and to let a second board emulate the sensor. All logic is in the clk domain; the SPI pins are oversampled.

Parameters:
DEVID, 8'hE5, value returned at address 0x00
BW_RATE_RST, 8'h0A, reset value of BW_RATE (0x2C)
SYNC_STAGES, 2, synchronizer depth for spi_csn/spi_sclk/spi_sdi (min 2)

Ports:
clk  in  1  system clock; must be ≥8× SCLK (25 MHz vs 2 MHz in this design)
rst  in  1  asynchronous, active-high reset
spi_csn  in  1  chip select, active low
spi_sclk  in  1  SPI clock, idles high (CPOL=1, CPHA=1)
spi_sdi  in  1  MOSI
spi_sdo  out  1  MISO data
spi_sdo_oe  out  1  MISO output enable (tri-state at top level)
sample_x, sample_y, sample_z  in  16 each  two's-complement axis samples
sample_valid  in  1  1-cycle strobe; loads sample_* into live registers
int1  out  1  DATA_READY interrupt
reg_bw_rate, reg_power_ctl, reg_data_format  out  8 each  current RW register contents
wr_strobe  out  1  1-cycle pulse on each committed SPI register write
wr_addr  out  6  address of the committed write
wr_data  out  8  data of the committed write

Behaviour:
- Inputs pass through SYNC_STAGES flops plus an edge detector. Internal events (csn fall/rise, sclk fall/rise) occur SYNC_STAGES+1 clk cycles after the pin edge.
- Command byte (MSB first): bit7 R/W (1=read), bit6 MB (multi-byte), bits5:0 address. Sample on sclk rise; shift out on sclk fall.
- States: IDLE -> (csn fall) CMD -> 8th rise -> RD_DATA or WR_DATA -> csn rise -> IDLE. A csn rise in any state returns to IDLE and clears the bit counter.
- On csn fall, live x/y/z are copied to a shadow. All reads of 0x32–0x37 in that transaction use the shadow, so multi-byte reads are coherent.
- Read: the data byte is loaded on the sclk fall after the 8th command rise. MSB is driven on that fall and each subsequent bit on following falls.
- spi_sdo_oe=1 only in RD_DATA while csn low. Otherwise it is 0 and spi_sdo=0.
- Write: a byte commits on its 8th sclk rise. The addressed RW register updates and wr_strobe pulses for one cycle with wr_addr/wr_data. Writes to RO or unmapped addresses are ignored, with no strobe. A partial byte at csn rise is discarded.
- Address after each data byte: MB=1 increments, wrapping 0x3F->0x00. MB=0 keeps the same address.
- Register map:
  - 0x00 DEVID (RO)
  - 0x2C BW_RATE (RW, reset BW_RATE_RST)
  - 0x2D POWER_CTL (RW, reset 0x00)
  - 0x2E INT_ENABLE (RW, reset 0x00)
  - 0x30 INT_SOURCE (RO; bit7 = DATA_READY, others 0)
  - 0x31 DATA_FORMAT (RW, reset 0x00)
  - 0x32–0x37 DATAX0, DATAX1, DATAY0, DATAY1, DATAZ0, DATAZ1 (RO, little-endian)
  - All other addresses read 0x00.
- DATA_READY is set the cycle after sample_valid. It clears when a read data byte at address 0x37 completes its 8th bit. If set and clear occur in the same cycle, set wins.
- int1 = DATA_READY & INT_ENABLE[7], registered.
- Reset values: all state IDLE; spi_sdo, spi_sdo_oe, int1, wr_strobe, wr_addr, wr_data = 0; live and shadow samples 0; DATA_READY 0; registers at their reset values. An asserted rst mid-transaction aborts it immediately. After rst falls, the responder waits for a fresh csn fall, ignoring the rest of any transaction already in progress.

Test Plan:
1. Command 0x80, 8 more SCLKs -> MISO reads 0xE5; spi_sdo_oe low before the first data fall and after csn rise.
2. Write 0x2D then 0x08 -> reg_power_ctl=0x08, one wr_strobe with wr_addr=0x2D, wr_data=0x08. Read 0xAD -> 0x08.
3. sample_x=0x0123, sample_y=0xFF80, sample_z=0x0100 with sample_valid, then read 0xF2 for 6 bytes -> 23 01 80 FF 00 01. A sample_valid with new values mid-transaction leaves the bytes unchanged.
4. Write INT_ENABLE=0x80, pulse sample_valid -> int1=1. Read 0xB0 -> 0x80. Multi-byte read 0xF2 through 0x37 -> int1=0. Re-pulse sample_valid in the same cycle the 0x37 byte completes -> int1 stays 1.
5. Write to 0x31 with csn raised after 4 data bits -> reg_data_format stays 0x00, no wr_strobe. The next transaction reads 0x31 -> 0x00.
6. Assert rst mid multi-byte write -> all outputs at reset values, reg_bw_rate=0x0A. A subsequent read of 0x2C -> 0x0A.
